key_conditioner: RTL and testbench

//   Input conditioning stage directly upstream of the project state machine.
//   - Takes the raw active-low board KEY buttons.
//   - Synchronises and debounces each key.
//   - Emits clean single-cycle press, release, long-press and auto-repeat

---
 rtl/key_pkg.sv | 31 +++
 rtl/key_debounce_ch.sv | 172 +++++++++++++++++
 rtl/key_conditioner.sv | 50 +++++
 tb/tb_key_conditioner.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
//   Shared definitions for the key conditioning path: per-key FSM state
//   encoding, default timing constants (50 MHz board clock) and small
//   elaboration-time helpers for sizing the counters.
// -----------------------------------------------------------------------------
package key_pkg;

  // Default timing, in clock cycles at 50 MHz.
  localparam int unsigned DB_CYCLES_DEF     = 32'd500000;    // 10 ms
  localparam int unsigned LONG_CYCLES_DEF   = 32'd50000000;  // 1 s
  localparam int unsigned REPEAT_CYCLES_DEF = 32'd10000000;  // 200 ms

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRESS_DB = 3'd1,
    ST_HELD     = 3'd2,
    ST_LONG     = 3'd3,
    ST_REL_DB   = 3'd4
  } key_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..max_count, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return ($clog2(max_count + 32'd1) < 1) ? 32'd1 : $clog2(max_count + 32'd1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
//   One key channel: two-flop synchroniser, debounce/hold FSM and counters.
//   Ports:
//     clk_i      system clock
//     rst_i      asynchronous reset, active-high
//     key_n_i    raw button, 0 = pressed
//     level_o    debounced level, 1 = pressed
//     press_o    1-cycle pulse on accepted press
//     release_o  1-cycle pulse on accepted release
//     long_o     1-cycle pulse after LONG_CYCLES of hold
//     repeat_o   1-cycle pulse every REPEAT_CYCLES once long-held
// -----------------------------------------------------------------------------
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int unsigned DB_W   = cnt_width(DB_CYCLES - 32'd1);
  localparam int unsigned HOLD_W = cnt_width(max_u(LONG_CYCLES, REPEAT_CYCLES) - 32'd1);

  localparam logic [DB_W-1:0]   DB_TERM   = DB_W'(DB_CYCLES - 32'd1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(32'd1);
  localparam logic [HOLD_W-1:0] LONG_TERM = HOLD_W'(LONG_CYCLES - 32'd1);
  localparam logic [HOLD_W-1:0] REP_TERM  = HOLD_W'(REPEAT_CYCLES - 32'd1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(32'd1);

  logic [1:0]        sync_q;
  logic              pressed_s;
  key_state_e        state_q, state_d;
  logic [DB_W-1:0]   db_q, db_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              from_long_q, from_long_d;   // REL_DB returns to LONG when set
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              repeat_q, repeat_d;

  // Synchronised key, inverted so that 1 means pressed.
  assign pressed_s = ~sync_q[1];

  // State, counters, synchroniser and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q      <= 2'b11;
      state_q     <= ST_IDLE;
      db_q        <= '0;
      hold_q      <= '0;
      from_long_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], key_n_i};
      state_q     <= state_d;
      db_q        <= db_d;
      hold_q      <= hold_d;
      from_long_q <= from_long_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  // Next-state, counter updates and pulse generation.
  // Counters stop at their terminal value because reaching it always
  // changes state or reloads to zero.
  always_comb begin
    state_d     = state_q;
    db_d        = db_q;
    hold_d      = hold_q;
    from_long_d = from_long_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pressed_s) begin
          state_d = ST_PRESS_DB;
          db_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PRESS_DB: begin
        if (!pressed_s) begin
          state_d = ST_IDLE;
        end else if (db_q == DB_TERM) begin
          state_d = ST_HELD;
          level_d = 1'b1;
          press_d = 1'b1;
          hold_d  = '0;
        end else begin
          db_d = db_q + DB_ONE;
        end
      end

      ST_HELD: begin
        if (!pressed_s) begin
          state_d     = ST_REL_DB;
          db_d        = '0;
          from_long_d = 1'b0;
        end else if (hold_q == LONG_TERM) begin
          state_d = ST_LONG;
          long_d  = 1'b1;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end

      ST_LONG: begin
        if (!pressed_s) begin
          state_d     = ST_REL_DB;
          db_d        = '0;
          from_long_d = 1'b1;
        end else if (hold_q == REP_TERM) begin
          repeat_d = 1'b1;
          hold_d   = '0;
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end

      ST_REL_DB: begin
        // A bounce back to pressed resumes the hold timing where it stopped.
        if (pressed_s) begin
          state_d = from_long_q ? ST_LONG : ST_HELD;
        end else if (db_q == DB_TERM) begin
          state_d   = ST_IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          db_d = db_q + DB_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        level_d = 1'b0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//   Conditions the raw active-low board KEYs for the project state machine:
//   one independent debounce channel per key, no shared logic.
//   Ports:
//     MAX10_CLK1_50  system clock, 50 MHz
//     RST            asynchronous reset, active-high
//     KEY            raw buttons, 0 = pressed
//     key_level      debounced level, 1 = pressed (LEDR debug)
//     press_pulse    1-cycle pulse on accepted press
//     release_pulse  1-cycle pulse on accepted release
//     long_pulse     1-cycle pulse after LONG_CYCLES held
//     repeat_pulse   1-cycle pulse every REPEAT_CYCLES after long_pulse
// -----------------------------------------------------------------------------
module key_conditioner
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS      = 32'd2,
  parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic                MAX10_CLK1_50,
  input  logic                RST,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES     (DB_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_ch (
      .clk_i     (MAX10_CLK1_50),
      .rst_i     (RST),
      .key_n_i   (KEY[g]),
      .level_o   (key_level[g]),
      .press_o   (press_pulse[g]),
      .release_o (release_pulse[g]),
      .long_o    (long_pulse[g]),
      .repeat_o  (repeat_pulse[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// -----------------------------------------------------------------------------
// tb_key_conditioner
//   Directed bench for key_conditioner with short timing (DB=4, LONG=20,
//   REPEAT=5). A run-length model of the key behaviour predicts every output
//   each cycle; directed scenarios also pin event timing to literal values.
// -----------------------------------------------------------------------------
module tb_key_conditioner;

  localparam int DB = 4;
  localparam int LG = 20;
  localparam int RP = 5;

  logic       clk;
  logic       RST;
  logic [1:0] KEY;
  logic [1:0] key_level;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;
  logic [1:0] long_pulse;
  logic [1:0] repeat_pulse;

  key_conditioner #(
    .NUM_KEYS      (2),
    .DB_CYCLES     (DB),
    .LONG_CYCLES   (LG),
    .REPEAT_CYCLES (RP)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .RST           (RST),
    .KEY           (KEY),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int ecount   = 0;   // number of rising edges completed

  // Model state per key.
  bit m_level [2];
  int m_run   [2];    // consecutive samples disagreeing with the accepted level
  int m_held  [2];    // pressed samples counted since the accepted press
  bit m_h0    [2];
  bit m_h1    [2];
  logic [1:0] exp_level, exp_press, exp_release, exp_long, exp_repeat;

  // First event edges observed on the DUT since the last clear.
  int press_e [2];
  int rel_e   [2];
  int long_e  [2];
  int lvl_e   [2];
  int rep1    [$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecount);
  endtask

  task automatic clear_ev();
    for (int k = 0; k < 2; k++) begin
      press_e[k] = -1;
      rel_e[k]   = -1;
      long_e[k]  = -1;
      lvl_e[k]   = -1;
    end
    rep1.delete();
  endtask

  // Model step and per-cycle comparison, once per clock on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      ecount++;
      exp_press   = 2'b00;
      exp_release = 2'b00;
      exp_long    = 2'b00;
      exp_repeat  = 2'b00;
      for (int k = 0; k < 2; k++) begin : model
        bit x;
        if (RST) begin
          m_level[k] = 1'b0;
          m_run[k]   = 0;
          m_held[k]  = 0;
          m_h0[k]    = 1'b1;
          m_h1[k]    = 1'b1;
        end else begin
          x = !m_h1[k];              // pressed, as seen two edges late
          m_h1[k] = m_h0[k];
          m_h0[k] = KEY[k];
          if (!m_level[k]) begin
            if (x) begin
              m_run[k]++;
              if (m_run[k] == DB + 1) begin
                m_level[k]   = 1'b1;
                m_run[k]     = 0;
                m_held[k]    = 0;
                exp_press[k] = 1'b1;
              end
            end else begin
              m_run[k] = 0;
            end
          end else begin
            if (!x) begin
              m_run[k]++;
              if (m_run[k] == DB + 1) begin
                m_level[k]     = 1'b0;
                m_run[k]       = 0;
                exp_release[k] = 1'b1;
              end
            end else if (m_run[k] > 0) begin
              m_run[k] = 0;           // release bounce: resume, this sample not counted
            end else begin
              m_held[k]++;
              if (m_held[k] == LG) exp_long[k] = 1'b1;
              else if (m_held[k] > LG && (m_held[k] - LG) % RP == 0) exp_repeat[k] = 1'b1;
            end
          end
        end
        exp_level[k] = m_level[k];
      end
      chk("key_level", key_level, exp_level);
      chk("press_pulse", press_pulse, exp_press);
      chk("release_pulse", release_pulse, exp_release);
      chk("long_pulse", long_pulse, exp_long);
      chk("repeat_pulse", repeat_pulse, exp_repeat);
      for (int k = 0; k < 2; k++) begin
        if (press_pulse[k] && press_e[k] < 0) press_e[k] = ecount;
        if (release_pulse[k] && rel_e[k] < 0) rel_e[k] = ecount;
        if (long_pulse[k] && long_e[k] < 0) long_e[k] = ecount;
        if (key_level[k] && lvl_e[k] < 0) lvl_e[k] = ecount;
      end
      if (repeat_pulse[1]) rep1.push_back(ecount);
    end
  end

  // Drive KEY for n clocks; changes land 2 time units after a falling edge.
  task automatic step(input logic [1:0] kv, input int n);
    KEY = kv;
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  int base, base_r, r0, r1;

  initial begin
    RST = 1'b1;
    KEY = 2'b11;
    clear_ev();
    @(negedge clk);
    #2;
    chk("rst_level", key_level, 0);
    chk("rst_pulses", press_pulse | release_pulse | long_pulse | repeat_pulse, 0);
    step(2'b11, 2);
    RST = 1'b0;
    step(2'b11, 5);

    // 1. clean press/release on key 0
    clear_ev();
    base = ecount + 1;
    step(2'b10, 10);
    base_r = ecount + 1;
    step(2'b11, 12);
    chk("t1_press_edge", press_e[0] - base, 6);
    chk("t1_level_edge", lvl_e[0] - base, 6);
    chk("t1_release_edge", rel_e[0] - base_r, 6);
    chk("t1_no_long", long_e[0], -1);
    chk("t1_key1_quiet", press_e[1], -1);

    // 2. press bounce rejected
    clear_ev();
    step(2'b10, 2);
    step(2'b11, 1);
    step(2'b10, 2);
    step(2'b11, 12);
    chk("t2_no_press", press_e[0], -1);
    chk("t2_no_level", lvl_e[0], -1);
    chk("t2_no_release", rel_e[0], -1);

    // 3. long press and auto-repeat on key 1
    clear_ev();
    base = ecount + 1;
    step(2'b01, 40);
    base_r = ecount + 1;
    step(2'b11, 12);
    r0 = (rep1.size() > 0) ? rep1[0] : -1000;
    r1 = (rep1.size() > 1) ? rep1[1] : -1000;
    chk("t3_press_edge", press_e[1] - base, 6);
    chk("t3_long_edge", long_e[1] - base, 26);
    chk("t3_repeat0_edge", r0 - base, 31);
    chk("t3_repeat1_edge", r1 - base, 36);
    chk("t3_release_edge", rel_e[1] - base_r, 6);

    // 4. release bounce rejected while held
    clear_ev();
    base = ecount + 1;
    step(2'b10, 10);
    step(2'b11, 2);
    step(2'b10, 5);
    chk("t4_no_release", rel_e[0], -1);
    chk("t4_level_held", key_level[0], 1);
    base_r = ecount + 1;
    step(2'b11, 12);
    chk("t4_release_edge", rel_e[0] - base_r, 6);

    // 5. both keys pressed on the same edge
    clear_ev();
    base = ecount + 1;
    step(2'b00, 10);
    chk("t5_press0_edge", press_e[0] - base, 6);
    chk("t5_press1_edge", press_e[1] - base, 6);
    step(2'b11, 12);

    // 6. reset while in LONG, key still held afterwards
    clear_ev();
    base = ecount + 1;
    step(2'b10, 30);
    chk("t6_long_edge", long_e[0] - base, 26);
    chk("t6_level_before", key_level[0], 1);
    RST = 1'b1;
    #1;
    chk("t6_rst_level", key_level, 0);
    chk("t6_rst_pulses", press_pulse | release_pulse | long_pulse | repeat_pulse, 0);
    #1;
    step(2'b10, 3);
    RST = 1'b0;
    clear_ev();
    base = ecount + 1;
    step(2'b10, 10);
    chk("t6_repress_edge", press_e[0] - base, 6);
    step(2'b11, 12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
